tfr_coalesce: RTL and testbench
===============================

TFR_COALESCE -- requirements
Module: tfr_coalesce

Interface
REQ-001 SHALL have parameter W, default 32, meaning data width in bits; W SHALL be a multiple of 8.
REQ-002 SHALL have parameter DEFAULT, default 0 (W bits), meaning the value the shadow register holds after reset.
REQ-003 SHALL have parameter LGREFRESH, default 16, meaning log2 of the refresh interval in cycles.
REQ-004 SHALL have a single clock and a synchronous, active-high reset.
REQ-005 SHALL provide these ports:
  i_clk  input  1  clock
  i_reset  input  1  synchronous active-high reset
  i_wr  input  1  write strobe for the shadow register
  i_wdata  input  W  write data
  i_wstrb  input  W/8  byte enables for i_wdata
  o_value  output  W  current shadow register value
  o_valid  output  1  stream valid toward the clock-crossing stage
  i_ready  input  1  stream ready from the clock-crossing stage
  o_data  output  W  stream data
  o_dropped  output  16  saturating count of superseded, unsent values

Function
REQ-006 Shadow r_value SHALL update on i_wr: for each byte lane b with i_wstrb[b]=1, take i_wdata lane b; other lanes SHALL be unchanged. o_value SHALL equal r_value.
REQ-007 Reference r_ref SHALL hold the value most recently loaded into o_data. pending SHALL be (r_value != r_ref) or the startup flag set.
REQ-008 The block SHALL have two states. IDLE: o_valid=0. SEND: o_valid=1.
REQ-009 In IDLE with pending: o_data<=r_value, r_ref<=r_value, clear startup flag, go to SEND.
REQ-010 In SEND with i_ready=1: reload as in REQ-009 and stay in SEND if pending; otherwise go to IDLE.
REQ-011 In SEND with i_ready=0: o_valid and o_data SHALL hold stable.
REQ-012 Loads SHALL use the registered r_value. A same-cycle i_wr SHALL become pending on the next cycle. Latency from i_wr to o_valid=1 from IDLE is 2 cycles.
REQ-013 Intermediate values overwritten before being loaded SHALL NOT be sent; only the latest value is forwarded.
REQ-014 o_dropped SHALL increment by 1 when i_wr changes r_value while r_value != r_ref and no load occurs that cycle. It SHALL saturate at 16'hFFFF.
REQ-015 A write that returns r_value to r_ref before a load SHALL cancel pending, with no transfer.
REQ-016 Back-to-back handshakes SHALL sustain one transfer per cycle when pending stays set.

Reset
REQ-017 On i_reset: r_value=DEFAULT, r_ref=DEFAULT, o_data=0, o_valid=0, state=IDLE, o_dropped=0, refresh counter=0, startup flag=1.
REQ-018 On the first clock edge after i_reset deasserts, the block SHALL load DEFAULT (startup flag); o_valid SHALL be 1 from that edge.
REQ-019 Reset asserted mid-transfer SHALL drop o_valid on the next edge, regardless of i_ready.
REQ-020 i_wr during i_reset SHALL be ignored.

Configuration
REQ-021 Macro TFR_REFRESH_EN defined: a counter SHALL run while in IDLE with no pending, and clear on any load or on leaving IDLE. When it reaches 2^LGREFRESH-1, the block SHALL reload r_value (re-send an unchanged value) and go to SEND. o_dropped SHALL not change.
REQ-022 Macro TFR_REFRESH_EN undefined: no refresh counter SHALL exist, and unchanged values SHALL never be re-sent.

Verification
REQ-023 Reset release, DEFAULT=32'h1234_5678, i_ready=1 -> one beat of o_data=32'h1234_5678, then o_valid=0.
REQ-024 IDLE, i_wr with i_wdata=32'hAABB_CCDD, i_wstrb=4'b0011, r_value=0 -> o_value=32'h0000_CCDD next cycle; o_valid=1 with that data two cycles after i_wr.
REQ-025 i_ready=0 held in SEND; writes of 1, 2, 3 on consecutive cycles -> o_data stable; o_dropped=2; after i_ready=1, the next beat is 3.
REQ-026 Write 5, then write back the original r_ref before a load (i_ready=0, SEND holding another value) -> no extra beat; o_dropped=1.
REQ-027 TFR_REFRESH_EN, LGREFRESH=4, idle with no writes -> o_valid pulses every 16 cycles with unchanged o_data; without the macro, o_valid stays 0.
REQ-028 Force 70000 dropped updates -> o_dropped=16'hFFFF, no wrap.

Source files
------------

// File: rtl/tfr_coalesce.sv
// Coalescing shadow register feeding a clock-crossing stream: only the latest value is sent.
// Define TFR_REFRESH_EN to periodically re-send an unchanged value after 2^LGREFRESH idle cycles.
module tfr_coalesce #(
  parameter int           W         = 32,
  parameter logic [W-1:0] DEFAULT   = '0,
  parameter int           LGREFRESH = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_wr,
  input  logic [W-1:0]   i_wdata,
  input  logic [W/8-1:0] i_wstrb,
  output logic [W-1:0]   o_value,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [W-1:0]   o_data,
  output logic [15:0]    o_dropped
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   value_q, value_d;
  logic [W-1:0]   ref_q, ref_d;
  logic [W-1:0]   data_q, data_d;
  logic [15:0]    dropped_q, dropped_d;
  logic           startup_q, startup_d;
  logic [W-1:0]   merged;
  logic           pending;
  logic           refresh_fire;
  logic           load;

`ifdef TFR_REFRESH_EN
  // Fires on the cycle the idle counter would step onto its final value.
  localparam logic [LGREFRESH-1:0] REFRESH_LAST = LGREFRESH'((1 << LGREFRESH) - 2);
  logic [LGREFRESH-1:0] refresh_cnt_q, refresh_cnt_d;
`else
  localparam int unused_lgrefresh = LGREFRESH;
`endif

  always_comb begin
    merged = value_q;
    for (int b = 0; b < W/8; b++) begin
      if (i_wstrb[b]) merged[8*b +: 8] = i_wdata[8*b +: 8];
    end

    pending = (value_q != ref_q) || startup_q;

`ifdef TFR_REFRESH_EN
    refresh_fire = (state_q == IDLE) && !pending && (refresh_cnt_q == REFRESH_LAST);
`else
    refresh_fire = 1'b0;
`endif

    load = (state_q == IDLE) ? (pending || refresh_fire) : (i_ready && pending);

    state_d   = state_q;
    value_d   = value_q;
    ref_d     = ref_q;
    data_d    = data_q;
    dropped_d = dropped_q;
    startup_d = startup_q;

    if (load) begin
      data_d    = value_q;
      ref_d     = value_q;
      startup_d = 1'b0;
      state_d   = SEND;
    end else if ((state_q == SEND) && i_ready) begin
      state_d = IDLE;
    end

    if (i_wr) value_d = merged;

    // A changed value that overwrites one still waiting to be loaded is lost.
    if (i_wr && (merged != value_q) && (value_q != ref_q) && !load &&
        (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end

`ifdef TFR_REFRESH_EN
    if ((state_q == IDLE) && !pending && !refresh_fire) refresh_cnt_d = refresh_cnt_q + 1'b1;
    else refresh_cnt_d = '0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      value_q   <= DEFAULT;
      ref_q     <= DEFAULT;
      data_q    <= '0;
      dropped_q <= '0;
      startup_q <= 1'b1;
`ifdef TFR_REFRESH_EN
      refresh_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      value_q   <= value_d;
      ref_q     <= ref_d;
      data_q    <= data_d;
      dropped_q <= dropped_d;
      startup_q <= startup_d;
`ifdef TFR_REFRESH_EN
      refresh_cnt_q <= refresh_cnt_d;
`endif
    end
  end

  assign o_value   = value_q;
  assign o_valid   = (state_q == SEND);
  assign o_data    = data_q;
  assign o_dropped = dropped_q;

endmodule

// File: tb/tb_tfr_coalesce.sv
// Directed testbench for tfr_coalesce: reset/startup beat, byte strobes, coalescing,
// cancellation, back-to-back transfers, mid-transfer reset, refresh and drop saturation.
module tb_tfr_coalesce;

  localparam logic [31:0] DEF = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] value;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic [15:0] dropped;

  int vectors = 0;
  int miscompares = 0;

  tfr_coalesce #(.W(32), .DEFAULT(DEF), .LGREFRESH(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_wr(wr), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_value(value), .o_valid(valid), .i_ready(ready), .o_data(data), .o_dropped(dropped)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; wr = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; ready = 1'b1;
    step(); step();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
    vectors++; if (value !== DEF) begin miscompares++; $display("[TB] FAIL reset_value got %h want %h", value, DEF); end
    vectors++; if (data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data got %h want 0", data); end
    vectors++; if (dropped !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_dropped got %h want 0", dropped); end
    reset = 1'b0; wr = 1'b0;
    step();
    vectors++; if (valid !== 1'b1 || data !== DEF) begin miscompares++; $display("[TB] FAIL startup_beat got v=%b d=%h want v=1 d=%h", valid, data, DEF); end
    step();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL startup_single got %b want 0", valid); end
  endtask

  task automatic test_partial_write();
    wr = 1'b1; wdata = 32'h0; wstrb = 4'hF;
    step();
    wr = 1'b0;
    step(); step();
    wr = 1'b1; wdata = 32'hAABB_CCDD; wstrb = 4'b0011;
    step();
    wr = 1'b0;
    vectors++; if (value !== 32'h0000_CCDD) begin miscompares++; $display("[TB] FAIL strobe_value got %h want 0000ccdd", value); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL strobe_latency1 got %b want 0", valid); end
    step();
    vectors++; if (valid !== 1'b1 || data !== 32'h0000_CCDD) begin miscompares++; $display("[TB] FAIL strobe_beat got v=%b d=%h want v=1 d=0000ccdd", valid, data); end
    step();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL strobe_idle got %b want 0", valid); end
  endtask

  task automatic test_coalesce();
    ready = 1'b0; wr = 1'b1; wdata = 32'hA0; wstrb = 4'hF;
    step();
    wr = 1'b0;
    step();
    for (int i = 1; i <= 3; i++) begin
      wr = 1'b1; wdata = i;
      step();
    end
    wr = 1'b0;
    vectors++; if (valid !== 1'b1 || data !== 32'hA0) begin miscompares++; $display("[TB] FAIL hold_stable got v=%b d=%h want v=1 d=a0", valid, data); end
    vectors++; if (dropped !== 16'd2) begin miscompares++; $display("[TB] FAIL coalesce_dropped got %0d want 2", dropped); end
    ready = 1'b1;
    step();
    vectors++; if (valid !== 1'b1 || data !== 32'h3) begin miscompares++; $display("[TB] FAIL coalesce_latest got v=%b d=%h want v=1 d=3", valid, data); end
    step();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL coalesce_idle got %b want 0", valid); end
  endtask

  task automatic test_cancel();
    ready = 1'b0; wr = 1'b1; wdata = 32'h55;
    step();
    wr = 1'b0;
    step();
    wr = 1'b1; wdata = 32'h5;
    step();
    wdata = 32'h55;
    step();
    wr = 1'b0;
    vectors++; if (dropped !== 16'd3) begin miscompares++; $display("[TB] FAIL cancel_dropped got %0d want 3", dropped); end
    ready = 1'b1;
    step();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("[TB] FAIL cancel_no_beat got %b want 0", valid); end
    step();
    vectors++; if (valid !== 1'b0 || data !== 32'h55) begin miscompares++; $display("[TB] FAIL cancel_idle got v=%b d=%h want v=0 d=55", valid, data); end
  endtask

  task automatic test_back_to_back();
    ready = 1'b1; wr = 1'b1; wdata = 32'h10;
    step();
    for (int i = 0; i < 3; i++) begin
      wr = (i < 2); wdata = 32'h11 + i;
      step();
      vectors++;
      if (valid !== 1'b1 || data !== 32'h10 + i) begin
        miscompares++; $display("[TB] FAIL b2b_beat%0d got v=%b d=%h want v=1 d=%h", i, valid, data, 32'h10 + i);
      end
    end
    wr = 1'b0;
    step();
    vectors++; if (valid !== 1'b0 || dropped !== 16'd3) begin miscompares++; $display("[TB] FAIL b2b_end got v=%b drop=%0d want v=0 drop=3", valid, dropped); end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0; wr = 1'b1; wdata = 32'h77;
    step();
    wr = 1'b0;
    step();
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_send got %b want 1", valid); end
    reset = 1'b1;
    step();
    vectors++; if (valid !== 1'b0 || data !== 32'h0 || dropped !== 16'h0) begin miscompares++; $display("[TB] FAIL mid_reset got v=%b d=%h drop=%0d want 0/0/0", valid, data, dropped); end
    reset = 1'b0; ready = 1'b1;
    step();
    vectors++; if (valid !== 1'b1 || data !== DEF) begin miscompares++; $display("[TB] FAIL mid_restart got v=%b d=%h want v=1 d=%h", valid, data, DEF); end
    step();
  endtask

  task automatic test_refresh();
    logic exp_v;
    ready = 1'b1; wr = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      step();
`ifdef TFR_REFRESH_EN
      exp_v = ((k % 16) == 15);
`else
      exp_v = 1'b0;
`endif
      vectors++;
      if (valid !== exp_v || (exp_v && data !== DEF)) begin
        miscompares++; $display("[TB] FAIL refresh_k%0d got v=%b d=%h want v=%b d=%h", k, valid, data, exp_v, DEF);
      end
    end
  endtask

  task automatic test_saturation();
    ready = 1'b0; wr = 1'b1; wdata = 32'hE0;
    step();
    wr = 1'b0;
    step();
    wr = 1'b1;
    for (int i = 0; i < 70001; i++) begin
      wdata = (i % 2 == 0) ? 32'h1 : 32'h2;
      step();
      if (i == 65534) begin
        vectors++; if (dropped !== 16'hFFFE) begin miscompares++; $display("[TB] FAIL sat_before got %h want fffe", dropped); end
      end
      if (i == 65535) begin
        vectors++; if (dropped !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_reach got %h want ffff", dropped); end
      end
    end
    wr = 1'b0;
    step();
    vectors++; if (dropped !== 16'hFFFF || valid !== 1'b1 || data !== 32'hE0) begin miscompares++; $display("[TB] FAIL sat_hold got drop=%h v=%b d=%h want ffff/1/e0", dropped, valid, data); end
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; wdata = '0; wstrb = '0; ready = 1'b0;
    test_reset();
    test_partial_write();
    test_coalesce();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    test_refresh();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
